// File: rtl/r16_addr_sched_if.sv
// Handshake/bus bundle for the radix-16 FFT read-address scheduler.
// The bench drives start/hold; the scheduler drives the read address.
interface r16_addr_sched_if #(
  parameter int A_WIDTH = 11
);
  logic               start;
  logic               hold;
  logic               rd_valid;
  logic               BN_out;
  logic [A_WIDTH-1:0] MA_out;
  logic [1:0]         stage_out;
  logic               busy;
  logic               done;

  modport master (
    output start, hold,
    input  rd_valid, BN_out, MA_out,
    input  stage_out, busy, done
  );

  modport slave (
    input  start, hold,
    output rd_valid, BN_out, MA_out,
    output stage_out, busy, done
  );
endinterface

// File: rtl/r16_addr_sched.sv
// Radix-16 FFT read-address scheduler: issues one BN/MA per cycle
// per stage, with a fixed writeback drain between stages.
module r16_addr_sched #(
  parameter int A_WIDTH   = 11,
  parameter int STAGE_NUM = 3,
  parameter int PIPE_LAT  = 48
) (
  input logic              clk,
  input logic              rst_n,
  r16_addr_sched_if.slave  bus
);
  localparam int CNT_W = A_WIDTH + 1;
  localparam int DW    = $clog2(PIPE_LAT);
  localparam logic [CNT_W-1:0] J_MAX = '1;
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [1:0] S_LAST = 2'(STAGE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   j_q, j_d;
  logic [1:0]         stage_q, stage_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               rd_valid_q, rd_valid_d;
  logic               bn_q, bn_d;
  logic [A_WIDTH-1:0] ma_q, ma_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Rotate j left by one hex digit per stage; bank = parity of digit LSBs.
  function automatic logic [CNT_W-1:0] map(
    input logic [CNT_W-1:0] j,
    input logic [1:0]       s
  );
    logic [2*CNT_W-1:0] w;
    logic [CNT_W-1:0]   idx;
    logic               bn;
    w   = {j, j} << (4 * s);
    idx = w[2*CNT_W-1:CNT_W];
    bn  = 1'b0;
    for (int k = 0; k < STAGE_NUM; k++) bn ^= idx[4*k];
    return {bn, idx[CNT_W-1:1]};
  endfunction

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    stage_d    = stage_q;
    drain_d    = drain_q;
    rd_valid_d = 1'b0;
    bn_d       = bn_q;
    ma_d       = ma_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = ISSUE;
          stage_d      = 2'd0;
          j_d          = '0;
          busy_d       = 1'b1;
          rd_valid_d   = 1'b1;
          {bn_d, ma_d} = map('0, 2'd0);
        end
      end
      ISSUE: begin
        if (!bus.hold) begin
          if (j_q != J_MAX) begin
            j_d          = j_q + 1'b1;
            rd_valid_d   = 1'b1;
            {bn_d, ma_d} = map(j_q + 1'b1, stage_q);
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q != D_LAST) begin
          drain_d = drain_q + 1'b1;
        end else if (stage_q != S_LAST) begin
          state_d      = ISSUE;
          stage_d      = stage_q + 2'd1;
          j_d          = '0;
          drain_d      = '0;
          rd_valid_d   = 1'b1;
          {bn_d, ma_d} = map('0, stage_q + 2'd1);
        end else begin
          state_d = DONE;
          stage_d = 2'd0;
          j_d     = '0;
          drain_d = '0;
          bn_d    = 1'b0;
          ma_d    = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      j_q        <= '0;
      stage_q    <= 2'd0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
      bn_q       <= 1'b0;
      ma_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      stage_q    <= stage_d;
      drain_q    <= drain_d;
      rd_valid_q <= rd_valid_d;
      bn_q       <= bn_d;
      ma_q       <= ma_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.BN_out    = bn_q;
  assign bus.MA_out    = ma_q;
  assign bus.stage_out = stage_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_r16_addr_sched.sv
// Directed bench for r16_addr_sched: full runs, hold, stray starts
// and asynchronous reset, with hand-computed addresses and timing.
module tb_r16_addr_sched;
  localparam int MAXC = 12450;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  logic        vv [0:MAXC];
  logic        bn [0:MAXC];
  logic [10:0] ma [0:MAXC];
  logic [1:0]  st [0:MAXC];
  logic        bz [0:MAXC];
  logic        dn [0:MAXC];

  r16_addr_sched_if #(.A_WIDTH(11)) bus ();

  r16_addr_sched #(
    .A_WIDTH(11), .STAGE_NUM(3), .PIPE_LAT(48)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
  endtask

  // Called at a negedge in IDLE. Cycle c = values after edge c-1.
  task automatic do_run(input int n,
                        input int h0, input int h0n,
                        input int h1, input int h1n,
                        input int s0, input int s1, input int s2);
    bus.hold  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      vv[c] = bus.rd_valid;
      bn[c] = bus.BN_out;
      ma[c] = bus.MA_out;
      st[c] = bus.stage_out;
      bz[c] = bus.busy;
      dn[c] = bus.done;
      bus.hold  = (c >= h0 && c < h0 + h0n) ||
                  (c >= h1 && c < h1 + h1n);
      bus.start = (c == s0) || (c == s1) || (c == s2);
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
  endtask

  function automatic int cnt_v(input int lo, input int hi);
    int k = 0;
    for (int c = lo; c <= hi; c++) if (vv[c]) k++;
    return k;
  endfunction

  function automatic int cnt_d(input int lo, input int hi);
    int k = 0;
    for (int c = lo; c <= hi; c++) if (dn[c]) k++;
    return k;
  endfunction

  function automatic int first_d(input int hi);
    for (int c = 1; c <= hi; c++) if (dn[c]) return c;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(bus.rd_valid), 0);
    chk({tag, "_bn"},    int'(bus.BN_out), 0);
    chk({tag, "_ma"},    int'(bus.MA_out), 0);
    chk({tag, "_stage"}, int'(bus.stage_out), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle");

    // Run 1: no hold, stray starts in ISSUE, DRAIN and DONE.
    do_run(MAXC, 0, 0, 0, 0, 50, 4120, 12433);
    chk("r1_v1",    int'(vv[1]), 1);
    chk("r1_bn_j0", int'(bn[1]), 0);
    chk("r1_ma_j0", int'(ma[1]), 'h000);
    chk("r1_bn_j1", int'(bn[2]), 1);
    chk("r1_ma_j1", int'(ma[2]), 'h000);
    chk("r1_bn_j2", int'(bn[3]), 0);
    chk("r1_ma_j2", int'(ma[3]), 'h001);
    chk("r1_bn_j123", int'(bn[292]), 0);
    chk("r1_ma_j123", int'(ma[292]), 'h091);
    chk("r1_bn_jfff", int'(bn[4096]), 1);
    chk("r1_ma_jfff", int'(ma[4096]), 'h7FF);
    chk("r1_s1_bn_j1", int'(bn[4146]), 1);
    chk("r1_s1_ma_j1", int'(ma[4146]), 'h008);
    chk("r1_s1_bn_j123", int'(bn[4436]), 0);
    chk("r1_s1_ma_j123", int'(ma[4436]), 'h118);
    chk("r1_s2_bn_j1", int'(bn[8290]), 1);
    chk("r1_s2_ma_j1", int'(ma[8290]), 'h080);
    chk("r1_st0", int'(st[1]), 0);
    chk("r1_st1", int'(st[4145]), 1);
    chk("r1_st2", int'(st[8289]), 2);
    chk("r1_st_done", int'(st[12433]), 0);
    chk("r1_s0_cnt", cnt_v(1, 4096), 4096);
    chk("r1_gap0", cnt_v(4097, 4144), 0);
    chk("r1_s1_v", int'(vv[4145]), 1);
    chk("r1_s1_cnt", cnt_v(4145, 8240), 4096);
    chk("r1_gap1", cnt_v(8241, 8288), 0);
    chk("r1_s2_v", int'(vv[8289]), 1);
    chk("r1_gap2", cnt_v(12385, 12432), 0);
    chk("r1_total", cnt_v(1, MAXC), 12288);
    chk("r1_done_at", first_d(MAXC), 12433);
    chk("r1_done_n", cnt_d(1, MAXC), 1);
    chk("r1_busy1", int'(bz[1]), 1);
    chk("r1_busy_pre", int'(bz[12432]), 1);
    chk("r1_busy_done", int'(bz[12433]), 0);
    chk("r1_after_v", cnt_v(12434, MAXC), 0);
    chk("r1_after_busy", int'(bz[MAXC]), 0);

    // Run 2: new run from IDLE; hold 10 cycles at j=100, hold in drain.
    do_run(MAXC, 101, 10, 4110, 30, 0, 0, 0);
    chk("r2_ma_j100", int'(ma[101]), 'h032);
    chk("r2_hold_v", cnt_v(102, 111), 0);
    chk("r2_hold_ma", int'(ma[111]), 'h032);
    chk("r2_bn_j101", int'(bn[112]), 1);
    chk("r2_ma_j101", int'(ma[112]), 'h032);
    chk("r2_ma_j102", int'(ma[113]), 'h033);
    chk("r2_s1_v", int'(vv[4155]), 1);
    chk("r2_total", cnt_v(1, MAXC), 12288);
    chk("r2_done_at", first_d(MAXC), 12443);
    chk("r2_done_n", cnt_d(1, MAXC), 1);

    // Run 3: async reset during stage 1 ISSUE, then a fresh run.
    do_run(5000, 0, 0, 0, 0, 0, 0, 0);
    chk("r3_st", int'(st[5000]), 1);
    chk("r3_v", int'(vv[5000]), 1);
    chk("r3_bn", int'(bn[5000]), 1);
    chk("r3_ma", int'(ma[5000]), 'h2B9);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("arst_idle");
    do_run(4, 0, 0, 0, 0, 0, 0, 0);
    chk("r3_v1", int'(vv[1]), 1);
    chk("r3_st1", int'(st[1]), 0);
    chk("r3_ma_j0", int'(ma[1]), 'h000);
    chk("r3_bn_j1", int'(bn[2]), 1);
    chk("r3_ma_j2", int'(ma[3]), 'h001);
    chk("r3_bn_j3", int'(bn[4]), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
